// File: rtl/gb_video_pkg.sv
// Shared definitions for the Game Boy pixel-stream receiver:
// frame geometry, receiver states and error-flag bit positions.
package gb_video_pkg;

  localparam int GB_H_ACTIVE  = 160;
  localparam int GB_V_ACTIVE  = 144;
  localparam int GB_FB_ADDR_W = 15;

  localparam int ERR_OVF   = 0;
  localparam int ERR_SHORT = 1;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/gb_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin followed by a
// rising-edge detector. The detected edge is a registered one-cycle pulse,
// so it appears SYNC_STAGES+1 clk edges after the pin changes.
module gb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  // Shift the pin through the synchronizer, then compare against the
  // previous synchronized level to find a 0 -> 1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/gb_video_rx.sv
// Game Boy pixel-stream receiver. Samples the asynchronous pclk/hsync/vsync/
// pixel pins, rebuilds (x, y) and produces a linear frame-buffer write port.
// Optional statistics counters are enabled by defining GB_VIDEO_RX_STATS_EN.
module gb_video_rx
  import gb_video_pkg::*;
#(
  parameter int H_ACTIVE    = GB_H_ACTIVE,
  parameter int V_ACTIVE    = GB_V_ACTIVE,
  parameter int ADDR_W      = GB_FB_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gb_pclk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  input  logic [1:0]        gb_pixel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              frame_done,
  output logic              locked,
`ifdef GB_VIDEO_RX_STATS_EN
  output logic [1:0]        err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
`else
  output logic [1:0]        err
`endif
);

  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gb_video_rx: SYNC_STAGES must be at least 2");
  end
  if ((64'd1 << ADDR_W) < 64'(H_ACTIVE) * 64'(V_ACTIVE)) begin : g_bad_addr
    $error("gb_video_rx: ADDR_W too small for H_ACTIVE*V_ACTIVE");
  end

  logic pclk_rise;
  logic hsync_rise;
  logic vsync_rise;

  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pclk_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gb_pclk),
    .rise (pclk_rise)
  );

  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hsync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gb_hsync),
    .rise (hsync_rise)
  );

  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gb_vsync),
    .rise (vsync_rise)
  );

  logic [1:0] pix_sync [SYNC_STAGES];
  logic [1:0] pix_q;

  // Pixel data follows the same depth as pclk plus one register, so pix_q is
  // valid in exactly the cycle that pclk_rise is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pix_sync[i] <= 2'b00;
      end
      pix_q <= 2'b00;
    end else begin
      pix_sync[0] <= gb_pixel;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pix_sync[i] <= pix_sync[i-1];
      end
      pix_q <= pix_sync[SYNC_STAGES-1];
    end
  end

  rx_state_t         state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] line_base;

  logic              px_write;
  logic              ev_ovf;
  logic              ev_short;
  logic              ev_frame;
  logic [X_W-1:0]    x_after;
  logic [Y_W-1:0]    y_next;

  // Classify this cycle's edges into write / error / frame events. vsync
  // takes priority; within a line the pixel is accounted before hsync.
  always_comb begin
    px_write = 1'b0;
    ev_ovf   = 1'b0;
    ev_short = 1'b0;
    ev_frame = 1'b0;
    x_after  = x;
    y_next   = y + Y_W'(1);
    case (state)
      ACTIVE: begin
        if (vsync_rise) begin
          ev_short = 1'b1;
        end else begin
          if (pclk_rise) begin
            if (x < X_W'(H_ACTIVE)) begin
              px_write = 1'b1;
            end else begin
              ev_ovf = 1'b1;
            end
          end
          x_after = x + X_W'(px_write);
          if (hsync_rise && (x_after != X_W'(H_ACTIVE))) begin
            ev_short = 1'b1;
          end
        end
      end
      DONE: begin
        if (vsync_rise) begin
          ev_frame = 1'b1;
        end else if (pclk_rise) begin
          ev_ovf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Receiver FSM with registered write port, status and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEEK;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 2'b00;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err        <= 2'b00;
    end else begin
      wr_en      <= px_write;
      frame_done <= ev_frame;
      if (px_write) begin
        wr_addr <= line_base + ADDR_W'(x);
        wr_data <= pix_q;
      end
      if (ev_ovf) begin
        err[ERR_OVF] <= 1'b1;
      end
      if (ev_short) begin
        err[ERR_SHORT] <= 1'b1;
      end
      case (state)
        SEEK: begin
          if (vsync_rise) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            state     <= ACTIVE;
            locked    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vsync_rise) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
          end else if (hsync_rise) begin
            x         <= '0;
            y         <= y_next;
            line_base <= line_base + ADDR_W'(H_ACTIVE);
            if (y_next == Y_W'(V_ACTIVE)) begin
              state <= DONE;
            end
          end else begin
            x <= x_after;
          end
        end
        DONE: begin
          if (vsync_rise) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            state     <= ACTIVE;
          end
        end
        default: begin
          state  <= SEEK;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef GB_VIDEO_RX_STATS_EN
  // Frame counter wraps; error counter saturates so a long soak stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
      err_cnt   <= 16'h0000;
    end else begin
      if (ev_frame) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end
      if ((ev_ovf || ev_short) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gb_video_rx.sv
// Directed bench for gb_video_rx. Line width is the real 160 pixels; the
// frame height is overridden to 8 lines so several complete frames fit in a
// short run. Every write is checked against an expected (address, shade)
// queue filled by the stimulus tasks.
module tb_gb_video_rx;
  import gb_video_pkg::*;

  localparam int H  = 160;
  localparam int V  = 8;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          gb_pclk;
  logic          gb_hsync;
  logic          gb_vsync;
  logic [1:0]    gb_pixel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          frame_done;
  logic          locked;
  logic [1:0]    err;
`ifdef GB_VIDEO_RX_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  gb_video_rx #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .ADDR_W      (AW),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gb_pclk    (gb_pclk),
    .gb_hsync   (gb_hsync),
    .gb_vsync   (gb_vsync),
    .gb_pixel   (gb_pixel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .locked     (locked),
`ifdef GB_VIDEO_RX_STATS_EN
    .err        (err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`else
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_wr = 0;
  int            n_fd = 0;
  logic [AW-1:0] last_addr = '0;

  // Write-port scoreboard and frame_done counter, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      n_wr++;
      last_addr = wr_addr;
      chk_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk_eq("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (frame_done) n_fd++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int yy, input int xx);
    wr_t w;
    w.addr = AW'(yy * H + xx);
    w.data = 2'((xx + yy) % 4);
    exp_q.push_back(w);
  endtask

  task automatic pix(input int yy, input int xx, input bit wr);
    gb_pixel = 2'((xx + yy) % 4);
    if (wr) expect_wr(yy, xx);
    gb_pclk = 1'b1;
    tick(2);
    gb_pclk = 1'b0;
    tick(2);
  endtask

  task automatic hsync_pulse();
    gb_hsync = 1'b1;
    tick(2);
    gb_hsync = 1'b0;
    tick(2);
  endtask

  task automatic vsync_pulse();
    gb_vsync = 1'b1;
    tick(2);
    gb_vsync = 1'b0;
    tick(2);
  endtask

  task automatic send_line(input int yy, input int npix);
    for (int xx = 0; xx < npix; xx++) pix(yy, xx, xx < H);
    hsync_pulse();
  endtask

  initial begin
    int lat;
    rst      = 1'b1;
    gb_pclk  = 1'b0;
    gb_hsync = 1'b0;
    gb_vsync = 1'b0;
    gb_pixel = 2'b00;
    tick(3);
    chk_eq("rst_wr_en",      32'(wr_en),      32'd0);
    chk_eq("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk_eq("rst_wr_data",    32'(wr_data),    32'd0);
    chk_eq("rst_frame_done", 32'(frame_done), 32'd0);
    chk_eq("rst_locked",     32'(locked),     32'd0);
    chk_eq("rst_err",        32'(err),        32'd0);
    rst = 1'b0;
    tick(2);

    // pclk before any vsync is ignored
    for (int i = 0; i < 3; i++) pix(0, i, 1'b0);
    tick(2);
    chk_eq("seek_locked", 32'(locked), 32'd0);
    chk_eq("seek_no_wr",  32'(n_wr),   32'd0);
    vsync_pulse();
    tick(2);
    chk_eq("vsync_locked", 32'(locked), 32'd1);

    // Frame 1: first pixel also measures pin-to-strobe latency
    n_wr = 0;
    expect_wr(0, 0);
    gb_pixel = 2'b00;
    gb_pclk  = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (wr_en && lat == 0) lat = i;
    end
    gb_pclk = 1'b0;
    tick(2);
    chk_eq("latency", 32'(lat), 32'd4);
    for (int xx = 1; xx < H; xx++) pix(0, xx, 1'b1);
    hsync_pulse();
    for (int yy = 1; yy < V; yy++) send_line(yy, H);
    tick(2);
    chk_eq("done_locked",  32'(locked), 32'd1);
    chk_eq("done_no_fd",   32'(n_fd),   32'd0);
    vsync_pulse();
    tick(2);
    chk_eq("f1_frame_done", 32'(n_fd),           32'd1);
    chk_eq("f1_writes",     32'(n_wr),           32'(H * V));
    chk_eq("f1_err",        32'(err),            32'd0);
    chk_eq("f1_queue",      32'(exp_q.size()),   32'd0);
`ifdef GB_VIDEO_RX_STATS_EN
    chk_eq("f1_frame_cnt",  32'(frame_cnt),      32'd1);
`endif

    // Frame 2: line 5 carries one extra pixel
    for (int yy = 0; yy < 5; yy++) send_line(yy, H);
    send_line(5, H + 1);
    tick(2);
    chk_eq("ovf_err", 32'(err), 32'd1);
    pix(6, 0, 1'b1);
    tick(4);
    chk_eq("l6_addr", 32'(last_addr), 32'd960);
    for (int xx = 1; xx < H; xx++) pix(6, xx, 1'b1);
    hsync_pulse();
    send_line(7, H);
    vsync_pulse();
    tick(2);
    chk_eq("f2_frame_done", 32'(n_fd), 32'd2);
    chk_eq("f2_err_sticky", 32'(err),  32'd1);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk_eq("rst2_err",    32'(err),    32'd0);
    chk_eq("rst2_locked", 32'(locked), 32'd0);

    // Frame 3: coincident pclk+hsync, then a short line
    vsync_pulse();
    send_line(0, H);
    for (int xx = 0; xx < H - 1; xx++) pix(1, xx, 1'b1);
    gb_pixel = 2'((H - 1 + 1) % 4);
    expect_wr(1, H - 1);
    gb_pclk  = 1'b1;
    gb_hsync = 1'b1;
    tick(2);
    gb_pclk  = 1'b0;
    gb_hsync = 1'b0;
    tick(4);
    chk_eq("coinc_addr", 32'(last_addr), 32'd319);
    chk_eq("coinc_err",  32'(err),       32'd0);
    pix(2, 0, 1'b1);
    tick(4);
    chk_eq("l2_addr", 32'(last_addr), 32'd320);
    for (int xx = 1; xx < H; xx++) pix(2, xx, 1'b1);
    hsync_pulse();
    send_line(3, 100);
    tick(2);
    chk_eq("short_err", 32'(err), 32'd2);
    pix(4, 0, 1'b1);
    tick(4);
    chk_eq("l4_addr", 32'(last_addr), 32'd640);
    for (int xx = 1; xx < H; xx++) pix(4, xx, 1'b1);
    hsync_pulse();
    for (int xx = 0; xx < 80; xx++) pix(5, xx, 1'b1);
    tick(4);
    chk_eq("pre_rst_queue", 32'(exp_q.size()), 32'd0);

    // Reset with a pixel still in the synchronizer
    gb_pixel = 2'b11;
    gb_pclk  = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_eq("midrst_wr_en",  32'(wr_en),  32'd0);
    chk_eq("midrst_err",    32'(err),    32'd0);
    chk_eq("midrst_locked", 32'(locked), 32'd0);
    gb_pclk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(6);
    n_wr = 0;
    pix(5, 80, 1'b0);
    pix(5, 81, 1'b0);
    tick(2);
    chk_eq("post_rst_no_wr", 32'(n_wr), 32'd0);
    vsync_pulse();
    pix(0, 0, 1'b1);
    tick(4);
    chk_eq("restart_addr",   32'(last_addr),    32'd0);
    chk_eq("restart_locked", 32'(locked),       32'd1);
    chk_eq("final_queue",    32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gb_video_rx.md
Name: gb_video_rx

Overview:
- Receiving end of the Game Boy pixel-stream pin interface (GB_PCLK, GB_HSYNC, GB_VSYNC, GB_PIXEL[1:0]) that the core drives out on header pins.
- Samples the asynchronous pin signals in a single local clock domain and reconstructs pixel coordinates.
- Emits a linear write port (address, 2-bit shade, strobe) for a 160x144 frame buffer.
- Used on a capture or display board, or in loopback to check the transmitted stream.

Parameters:
- H_ACTIVE, 160: pixels per line.
- V_ACTIVE, 144: lines per frame.
- ADDR_W, 15: write-address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- SYNC_STAGES, 2: flip-flop stages per input synchronizer; must be >= 2.

Ports:
- clk  in  1  sampling clock; at least 4x the gb_pclk frequency.
- rst  in  1  synchronous, active-high reset.
- gb_pclk  in  1  async; one rising edge per visible pixel; no edges during blanking.
- gb_hsync  in  1  async; rising edge ends a line.
- gb_vsync  in  1  async; rising edge starts a frame.
- gb_pixel  in  2  async; stable around each gb_pclk rising edge.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  address, equal to y*H_ACTIVE + x.
- wr_data  out  2  pixel shade.
- frame_done  out  1  one-cycle pulse when a complete frame is received.
- locked  out  1  high while in ACTIVE or DONE.
- err  out  2  sticky flags: [0] overflow (extra pixel or line), [1] short line or short frame.

Behaviour:
- Reset values: every output is 0; internal x, y and line_base are 0; state is SEEK.
- Input synchronizers:
  - Each input passes through SYNC_STAGES flops.
  - gb_pixel is synchronized alongside gb_pclk and sampled on the same cycle as the gb_pclk edge.
- Edge detection:
  - Rising-edge detection uses one extra register on the synchronized pclk, hsync and vsync.
  - A rising edge is a 0 then 1 pair on consecutive cycles.
- Latency: wr_en rises exactly SYNC_STAGES+2 clk cycles after the gb_pclk pin rising edge.
- State SEEK:
  - Ignore pclk and hsync edges.
  - On a vsync edge: x=0, y=0, line_base=0, go to ACTIVE.
- State ACTIVE:
  - pclk edge with x < H_ACTIVE: wr_en=1, wr_addr=line_base+x, wr_data=pixel, then x++.
  - pclk edge with x == H_ACTIVE: drop the pixel, set err[0].
  - hsync edge:
    - If x != H_ACTIVE, set err[1].
    - Then x=0, y++, line_base += H_ACTIVE.
    - If the new y == V_ACTIVE, go to DONE.
  - No multiplier: addresses come from the running line_base adder only.
- State DONE:
  - pclk edges are dropped and set err[0]; hsync edges are ignored.
  - On a vsync edge: pulse frame_done, reset x, y and line_base, go to ACTIVE.
- vsync edge in ACTIVE (short frame): set err[1], no frame_done, restart coordinates, stay in ACTIVE.
- Simultaneous events in one cycle:
  - pclk+hsync: the pixel is written to the current line first, then the line advances.
  - vsync+any: vsync wins; a coincident pclk pixel is dropped without an error.
- Reset mid-frame: any pending wr_en is suppressed next cycle; err clears; state returns to SEEK and the remainder of the frame is discarded.
- err bits clear only on rst.

Optional Feature:
- Macro GB_VIDEO_RX_STATS_EN.
- When defined, adds two outputs:
  - frame_cnt (16 bits): increments on each frame_done and wraps.
  - err_cnt (16 bits): increments on each error event and saturates at 16'hFFFF.
- Both counters reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package gb_video_pkg holds:
  - constants GB_H_ACTIVE=160, GB_V_ACTIVE=144, GB_FB_ADDR_W=15;
  - the receiver state enum (SEEK, ACTIVE, DONE);
  - error-bit index constants ERR_OVF=0, ERR_SHORT=1.
- One sub-module, gb_sync_edge: a parameterized SYNC_STAGES synchronizer plus a rising-edge detector, instantiated once per control input.

Test Plan:
- Reset, then a vsync pulse followed by 144 lines of 160 pixels with shade (x+y)%4, then vsync:
  - exactly 23040 wr_en strobes at addresses 0..23039 with matching data;
  - one frame_done pulse; err=0.
- pclk edges before the first vsync:
  - no wr_en; locked=0 until the vsync edge, then locked=1.
- Line 5 with 161 pixels:
  - the 161st pixel is dropped; err[0]=1;
  - line 6 starts at address 960.
- Line 3 with 100 pixels:
  - err[1]=1; line 4 still starts at address 640.
- A single pin pclk edge:
  - wr_en rises exactly 4 clk cycles later (SYNC_STAGES=2).
  - pclk and hsync edges arriving in the same cycle: the pixel lands at the current line's address before the line increments.
- Assert rst midway through line 70:
  - wr_en=0 the next cycle; err=0; locked=0;
  - the next vsync restarts capture at address 0.
